// File: rtl/cajero_automatico_param.sv
// cajero_automatico_param: ATM transaction controller. It handles card detect, PIN entry
// with retry and lockout, and a deposit or withdrawal against a balance latched at insert.
// Optional feature macro: LIMITE_RETIRO_EN. It enables the per-transaction withdrawal cap;
// without it, limite_excedido stays 0.
module cajero_automatico_param #(
  parameter int          PIN_DIGITS    = 4,
  parameter int          BALANCE_W     = 64,
  parameter int          MONTO_W       = 32,
  parameter int          MAX_INTENTOS  = 3,
  parameter int unsigned LIMITE_RETIRO = 32'd500000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tarjeta_recibida,
  input  logic                    tipo_trans,
  input  logic                    digito_stb,
  input  logic [3:0]              digito,
  input  logic [4*PIN_DIGITS-1:0] pin,
  input  logic [BALANCE_W-1:0]    balance_inicial,
  input  logic [MONTO_W-1:0]      monto,
  input  logic                    monto_stb,
  output logic [BALANCE_W-1:0]    balance,
  output logic                    balance_actualizado,
  output logic                    entregar_dinero,
  output logic                    pin_incorrecto,
  output logic                    advertencia,
  output logic                    bloqueo,
  output logic                    fondos_insuficientes,
  output logic                    limite_excedido
);
  localparam int PIN_W = 4 * PIN_DIGITS;
  localparam int CW    = $clog2(PIN_DIGITS + 1);
  localparam int IW    = $clog2(MAX_INTENTOS + 1);
  localparam logic [CW-1:0] ULTIMO_DIGITO  = CW'(PIN_DIGITS - 1);
  localparam logic [IW-1:0] INTENTOS_MAX   = IW'(MAX_INTENTOS);
  localparam logic [IW-1:0] INTENTOS_AVISO = IW'(MAX_INTENTOS - 1);
  localparam logic [BALANCE_W-1:0] LIMITE  = BALANCE_W'(LIMITE_RETIRO);
`ifdef LIMITE_RETIRO_EN
  localparam logic LIMITE_ACTIVO = 1'b1;
`else
  localparam logic LIMITE_ACTIVO = 1'b0;
`endif

  typedef enum logic [2:0] {
    ESPERA_TARJETA = 3'd0,
    RECIBE_PIN     = 3'd1,
    VERIFICA_PIN   = 3'd2,
    ESPERA_MONTO   = 3'd3,
    PROCESA        = 3'd4,
    BLOQUEO        = 3'd5
  } estado_t;

  // Balance + amount, clamped to all-ones instead of wrapping.
  function automatic logic [BALANCE_W-1:0] suma_saturada(input logic [BALANCE_W-1:0] a,
                                                         input logic [BALANCE_W-1:0] b);
    logic [BALANCE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[BALANCE_W]) return {BALANCE_W{1'b1}};
    else              return s[BALANCE_W-1:0];
  endfunction

  estado_t              estado_r, estado_sig_s;
  logic [BALANCE_W-1:0] balance_r, balance_sig_s, monto_ext_s;
  logic [PIN_W-1:0]     digitos_r, digitos_sig_s;
  logic [CW-1:0]        cuenta_r, cuenta_sig_s;
  logic [IW-1:0]        intentos_r, intentos_sig_s, intentos_inc_s;
  logic [MONTO_W-1:0]   monto_r, monto_sig_s;
  logic                 tipo_r, tipo_sig_s;
  logic                 esperar_retiro_r, esperar_retiro_sig_s;
  logic                 actualizado_r, actualizado_s;
  logic                 entregar_r, entregar_s;
  logic                 pin_inc_r, pin_inc_s;
  logic                 adv_r, adv_s;
  logic                 bloq_r, bloq_s;
  logic                 fondos_r, fondos_s;
  logic                 limite_r, limite_s;
  logic                 excede_limite_s;

  assign monto_ext_s     = BALANCE_W'(monto_r);
  assign intentos_inc_s  = intentos_r + IW'(1);
  assign excede_limite_s = LIMITE_ACTIVO & (monto_ext_s > LIMITE);

  // Next-state, datapath and output-pulse decode; card removal pre-empts every strobe.
  always_comb begin
    estado_sig_s         = estado_r;
    balance_sig_s        = balance_r;
    digitos_sig_s        = digitos_r;
    cuenta_sig_s         = cuenta_r;
    intentos_sig_s       = intentos_r;
    monto_sig_s          = monto_r;
    tipo_sig_s           = tipo_r;
    esperar_retiro_sig_s = esperar_retiro_r;
    actualizado_s        = 1'b0;
    entregar_s           = 1'b0;
    pin_inc_s            = 1'b0;
    fondos_s             = 1'b0;
    limite_s             = 1'b0;
    adv_s                = adv_r;
    bloq_s               = bloq_r;
    case (estado_r)
      ESPERA_TARJETA: begin
        // After a completed transaction the card must be pulled before a new one starts.
        if (!tarjeta_recibida) begin
          esperar_retiro_sig_s = 1'b0;
        end else if (!esperar_retiro_r) begin
          balance_sig_s = balance_inicial;
          digitos_sig_s = '0;
          cuenta_sig_s  = '0;
          estado_sig_s  = RECIBE_PIN;
        end else begin
          estado_sig_s = ESPERA_TARJETA;
        end
      end
      RECIBE_PIN: begin
        if (!tarjeta_recibida) begin
          digitos_sig_s = '0;
          cuenta_sig_s  = '0;
          estado_sig_s  = ESPERA_TARJETA;
        end else if (digito_stb) begin
          digitos_sig_s = (digitos_r << 4) | PIN_W'(digito);
          if (cuenta_r == ULTIMO_DIGITO) begin
            cuenta_sig_s = '0;
            estado_sig_s = VERIFICA_PIN;
          end else begin
            cuenta_sig_s = cuenta_r + CW'(1);
          end
        end else begin
          estado_sig_s = RECIBE_PIN;
        end
      end
      VERIFICA_PIN: begin
        digitos_sig_s = '0;
        cuenta_sig_s  = '0;
        if (!tarjeta_recibida) begin
          estado_sig_s = ESPERA_TARJETA;
        end else if (digitos_r == pin) begin
          intentos_sig_s = '0;
          adv_s          = 1'b0;
          estado_sig_s   = ESPERA_MONTO;
        end else begin
          intentos_sig_s = intentos_inc_s;
          pin_inc_s      = 1'b1;
          if (intentos_inc_s == INTENTOS_MAX) begin
            bloq_s       = 1'b1;
            adv_s        = 1'b0;
            estado_sig_s = BLOQUEO;
          end else begin
            adv_s        = (intentos_inc_s == INTENTOS_AVISO);
            estado_sig_s = RECIBE_PIN;
          end
        end
      end
      ESPERA_MONTO: begin
        if (!tarjeta_recibida) begin
          estado_sig_s = ESPERA_TARJETA;
        end else if (monto_stb) begin
          monto_sig_s  = monto;
          tipo_sig_s   = tipo_trans;
          estado_sig_s = PROCESA;
        end else begin
          estado_sig_s = ESPERA_MONTO;
        end
      end
      PROCESA: begin
        estado_sig_s = ESPERA_TARJETA;
        if (!tarjeta_recibida) begin
          esperar_retiro_sig_s = 1'b0;
        end else begin
          esperar_retiro_sig_s = 1'b1;
          if (!tipo_r) begin
            balance_sig_s = suma_saturada(balance_r, monto_ext_s);
            actualizado_s = 1'b1;
          end else if (excede_limite_s) begin
            limite_s = 1'b1;
          end else if (monto_ext_s > balance_r) begin
            fondos_s = 1'b1;
          end else begin
            balance_sig_s = balance_r - monto_ext_s;
            actualizado_s = 1'b1;
            entregar_s    = 1'b1;
          end
        end
      end
      BLOQUEO: begin
        estado_sig_s = BLOQUEO;
        bloq_s       = 1'b1;
        adv_s        = 1'b0;
      end
      default: begin
        estado_sig_s = ESPERA_TARJETA;
      end
    endcase
  end

  // State register; reset returns to waiting for a card, even from lockout.
  always_ff @(posedge clock) begin
    if (!reset) estado_r <= ESPERA_TARJETA;
    else        estado_r <= estado_sig_s;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      balance_r        <= '0;
      digitos_r        <= '0;
      cuenta_r         <= '0;
      intentos_r       <= '0;
      monto_r          <= '0;
      tipo_r           <= 1'b0;
      esperar_retiro_r <= 1'b0;
      actualizado_r    <= 1'b0;
      entregar_r       <= 1'b0;
      pin_inc_r        <= 1'b0;
      adv_r            <= 1'b0;
      bloq_r           <= 1'b0;
      fondos_r         <= 1'b0;
      limite_r         <= 1'b0;
    end else begin
      balance_r        <= balance_sig_s;
      digitos_r        <= digitos_sig_s;
      cuenta_r         <= cuenta_sig_s;
      intentos_r       <= intentos_sig_s;
      monto_r          <= monto_sig_s;
      tipo_r           <= tipo_sig_s;
      esperar_retiro_r <= esperar_retiro_sig_s;
      actualizado_r    <= actualizado_s;
      entregar_r       <= entregar_s;
      pin_inc_r        <= pin_inc_s;
      adv_r            <= adv_s;
      bloq_r           <= bloq_s;
      fondos_r         <= fondos_s;
      limite_r         <= limite_s;
    end
  end

  assign balance              = balance_r;
  assign balance_actualizado  = actualizado_r;
  assign entregar_dinero      = entregar_r;
  assign pin_incorrecto       = pin_inc_r;
  assign advertencia          = adv_r;
  assign bloqueo              = bloq_r;
  assign fondos_insuficientes = fondos_r;
  assign limite_excedido      = limite_r;
endmodule
